// File: rtl/add_pipe.sv
// add_pipe: pipelined ripple-segment adder, {o_cout,o_sum} = i_a + i_b + i_cin.
// The carry chain is cut into STAGES slices of SLICE = WIDTH/STAGES bits, one
// slice per register stage. A single advance enable (output empty or being
// taken) moves the whole pipe, so a stalled output freezes every stage.
// Optional feature macro: ADD_PIPE_OVF_EN adds the registered o_ovf output.
module add_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef ADD_PIPE_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int SLICE = WIDTH / STAGES;

  logic              w_en;
  logic [STAGES-1:0] r_vld;

  // The pipe moves only when the output slot is empty or being consumed.
  assign w_en        = !r_vld[STAGES-1] || i_out_ready;
  assign o_in_ready  = w_en;
  assign o_out_valid = r_vld[STAGES-1];

  if (STAGES == 1) begin : g_vld1
    // Valid bit of the single stage.
    always_ff @(posedge clk or posedge rst)
      if (rst)       r_vld <= '0;
      else if (w_en) r_vld <= i_in_valid;
  end else begin : g_vldn
    // Valid bits shift one stage per advance; a new beat enters at stage 0.
    always_ff @(posedge clk or posedge rst)
      if (rst)       r_vld <= '0;
      else if (w_en) r_vld <= {r_vld[STAGES-2:0], i_in_valid};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // HI: number of low sum bits complete once this stage has registered.
    localparam int HI = (k + 1) * SLICE;

    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic             w_ci;
    logic [SLICE:0]   w_add;
    logic [HI-1:0]    r_s;
    logic             r_c;

    assign w_add = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE{1'b0}}, w_ci};

    if (k == 0) begin : g_src
      assign w_sa = i_a[SLICE-1:0];
      assign w_sb = i_b[SLICE-1:0];
      assign w_ci = i_cin;

      // Slice 0 of the sum straight from the operand inputs.
      always_ff @(posedge clk or posedge rst)
        if (rst)       r_s <= '0;
        else if (w_en) r_s <= w_add[SLICE-1:0];
    end else begin : g_src
      // Slice k sits at the bottom of the operand bits carried by stage k-1.
      assign w_sa = g_stg[k-1].g_ops.r_a[SLICE-1:0];
      assign w_sb = g_stg[k-1].g_ops.r_b[SLICE-1:0];
      assign w_ci = g_stg[k-1].r_c;

      // New slice on top of the lower sum bits forwarded unchanged.
      always_ff @(posedge clk or posedge rst)
        if (rst)       r_s <= '0;
        else if (w_en) r_s <= {w_add[SLICE-1:0], g_stg[k-1].r_s};
    end

    // Slice carry; the last stage's carry is the adder's carry-out.
    always_ff @(posedge clk or posedge rst)
      if (rst)       r_c <= 1'b0;
      else if (w_en) r_c <= w_add[SLICE];

    if (k < STAGES - 1) begin : g_ops
      // Operand bits not yet summed, i.e. original bits [WIDTH-1:HI].
      logic [WIDTH-HI-1:0] r_a;
      logic [WIDTH-HI-1:0] r_b;

      if (k == 0) begin : g_ld
        // Capture the upper operand bits on accept.
        always_ff @(posedge clk or posedge rst)
          if (rst) begin
            r_a <= '0;
            r_b <= '0;
          end else if (w_en) begin
            r_a <= i_a[WIDTH-1:HI];
            r_b <= i_b[WIDTH-1:HI];
          end
      end else begin : g_ld
        // Drop the slice consumed here and pass the rest down the pipe.
        always_ff @(posedge clk or posedge rst)
          if (rst) begin
            r_a <= '0;
            r_b <= '0;
          end else if (w_en) begin
            r_a <= g_stg[k-1].g_ops.r_a[WIDTH-HI+SLICE-1:SLICE];
            r_b <= g_stg[k-1].g_ops.r_b[WIDTH-HI+SLICE-1:SLICE];
          end
      end
    end
  end

  assign o_sum  = g_stg[STAGES-1].r_s;
  assign o_cout = g_stg[STAGES-1].r_c;

`ifdef ADD_PIPE_OVF_EN
  // The top slice holds the operand MSBs, so overflow is judged there.
  logic w_ovf;
  logic r_ovf;

  assign w_ovf = (g_stg[STAGES-1].w_sa[SLICE-1] == g_stg[STAGES-1].w_sb[SLICE-1]) &&
                 (g_stg[STAGES-1].w_add[SLICE-1] != g_stg[STAGES-1].w_sa[SLICE-1]);

  // Overflow flag registered alongside the final sum slice.
  always_ff @(posedge clk or posedge rst)
    if (rst)       r_ovf <= 1'b0;
    else if (w_en) r_ovf <= w_ovf;

  assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: scoreboard bench for add_pipe. Three instances (STAGES=2, 1, 8;
// WIDTH=8). Drivers push expected {ovf,cout,sum} on accept; a monitor pops and
// compares whenever an instance retires a result.
module tb_add_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  logic rand_en;

  logic [2:0] iv;
  logic [2:0] ci;
  logic [7:0] ia [3];
  logic [7:0] ib [3];
  logic       ordy0;
  logic [2:1] ordyr;
  logic [2:0] ordy;
  assign ordy = {ordyr, ordy0};

  logic       ir [3];
  logic       ov [3];
  logic       co [3];
  logic [7:0] so [3];
`ifdef ADD_PIPE_OVF_EN
  logic       of [3];
`endif

  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  logic [9:0] q2 [$];

  add_pipe #(.WIDTH(8), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .i_in_valid(iv[0]), .o_in_ready(ir[0]),
    .i_a(ia[0]), .i_b(ib[0]), .i_cin(ci[0]), .o_out_valid(ov[0]),
    .i_out_ready(ordy[0]), .o_sum(so[0]), .o_cout(co[0])
`ifdef ADD_PIPE_OVF_EN
    , .o_ovf(of[0])
`endif
  );
  add_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .i_in_valid(iv[1]), .o_in_ready(ir[1]),
    .i_a(ia[1]), .i_b(ib[1]), .i_cin(ci[1]), .o_out_valid(ov[1]),
    .i_out_ready(ordy[1]), .o_sum(so[1]), .o_cout(co[1])
`ifdef ADD_PIPE_OVF_EN
    , .o_ovf(of[1])
`endif
  );
  add_pipe #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .rst(rst), .i_in_valid(iv[2]), .o_in_ready(ir[2]),
    .i_a(ia[2]), .i_b(ib[2]), .i_cin(ci[2]), .o_out_valid(ov[2]),
    .i_out_ready(ordy[2]), .o_sum(so[2]), .o_cout(co[2])
`ifdef ADD_PIPE_OVF_EN
    , .o_ovf(of[2])
`endif
  );

  function automatic logic [9:0] model(logic [7:0] a, logic [7:0] b, logic c);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + {8'd0, c};
    return {(a[7] == b[7]) && (s[7] != a[7]), s};
  endfunction

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(int d, logic [9:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [9:0] qpop(int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Compares every retired result against the head of that instance's queue.
  task automatic monitor();
    logic [9:0] g;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 3; d++) begin
          if (ov[d] && ordy[d]) begin
            g = {1'b0, co[d], so[d]};
`ifdef ADD_PIPE_OVF_EN
            g[9] = of[d];
`endif
            checks++;
            if (qsize(d) == 0) begin
              errors++;
              $display("FAIL out_unexpected dut=%0d got=%h expected=none", d, g);
            end else begin
              e = qpop(d);
`ifndef ADD_PIPE_OVF_EN
              e[9] = 1'b0;
`endif
              if (g !== e) begin
                errors++;
                $display("FAIL out_data dut=%0d got=%h expected=%h", d, g, e);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      ordyr[1] = !rand_en || ($urandom_range(0, 3) != 0);
      ordyr[2] = !rand_en || ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic cycle_count();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // Present a beat, hold it until taken, record its expected result.
  task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [9:0] e);
    int n;
    n = 0;
    iv[d] = 1'b1;
    ia[d] = a;
    ib[d] = b;
    ci[d] = c;
    @(negedge clk);
    while (!ir[d] && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!ir[d]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut=%0d got=stalled expected=accept", d);
    end else begin
      qpush(d, e);
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
  endtask

  // Edges from presenting a beat into an idle pipe until out_valid shows.
  task automatic measure(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [9:0] e, input int lat);
    int n;
    iv[d] = 1'b1;
    ia[d] = a;
    ib[d] = b;
    ci[d] = c;
    qpush(d, e);
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    n = 1;
    while (!ov[d] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("latency_dut%0d", d), n, lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qsize(0) + qsize(1) + qsize(2)) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", qsize(0) + qsize(1) + qsize(2), 0);
  endtask

  task automatic rdrive(input int d);
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      send(d, a, b, c, model(a, b, c));
    end
  endtask

  initial begin
    logic [7:0] hs;
    logic       hc;
    logic [7:0] i8;
    int         t0;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rand_en = 1'b0;
    rst     = 1'b0;
    iv      = '0;
    ci      = '0;
    ordy0   = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ia[d] = '0;
      ib[d] = '0;
    end
    fork
      monitor();
      ready_driver();
      cycle_count();
    join_none

    // Reset state
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_out_valid_dut%0d", d), ov[d], 0);
      chk($sformatf("rst_sum_dut%0d", d), so[d], 0);
      chk($sformatf("rst_cout_dut%0d", d), co[d], 0);
`ifdef ADD_PIPE_OVF_EN
      chk($sformatf("rst_ovf_dut%0d", d), of[d], 0);
`endif
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("in_ready_after_reset", ir[0], 1);

    // Basic sums and the carry crossing the slice boundary
    measure(0, 8'h0F, 8'h01, 1'b0, 10'h010, 2);
    send(0, 8'hFF, 8'h01, 1'b0, 10'h100);
    drain();

    // Back-to-back: 16 beats must take exactly 16 edges
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      i8 = 8'(i);
      send(0, i8, 8'hF0, i8[0], model(i8, 8'hF0, i8[0]));
    end
    chk("b2b_edges", cyc - t0, 16);
    drain();

    // Back-pressure: two beats in, output held for 5 cycles
    ordy0 = 1'b0;
    send(0, 8'h33, 8'h44, 1'b1, 10'h078);
    send(0, 8'hA0, 8'h70, 1'b0, 10'h110);
    chk("stall_out_valid", ov[0], 1);
    hs = so[0];
    hc = co[0];
    iv[0] = 1'b1;
    ia[0] = 8'h55;
    ib[0] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", ir[0], 0);
      chk("stall_sum_hold", so[0], hs);
      chk("stall_cout_hold", co[0], hc);
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    ordy0 = 1'b1;
    drain();

    // Reset mid-stream with two beats in flight
    send(0, 8'h11, 8'h22, 1'b0, 10'h033);
    send(0, 8'h44, 8'h22, 1'b0, 10'h066);
    rst = 1'b1;
    q0.delete();
    #1;
    chk("midrst_out_valid", ov[0], 0);
    chk("midrst_sum", so[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("midrst_no_stale", ov[0], 0);
    send(0, 8'h01, 8'h01, 1'b0, 10'h002);
    drain();

    // Signed-overflow vectors (ovf compared only when the port exists)
    send(0, 8'h7F, 8'h01, 1'b0, 10'h280);
    send(0, 8'h80, 8'h80, 1'b0, 10'h300);
    send(0, 8'h01, 8'hFF, 1'b0, 10'h100);
    drain();

    // STAGES=1 and STAGES=8: latency, then random traffic with back-pressure
    measure(1, 8'h12, 8'h34, 1'b1, 10'h047, 1);
    measure(2, 8'hC8, 8'h64, 1'b0, 10'h12C, 8);
    drain();
    rand_en = 1'b1;
    fork
      rdrive(1);
      rdrive(2);
    join
    rand_en = 1'b0;
    repeat (2) @(posedge clk);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
